// File: rtl/mem_dual_port_resp.sv
// Dual-port memory responder: post-reset clear sequence, registered reads with valid strobes,
// and same-address collision flagging/counting. Optional MEM_BYPASS_EN makes cross-port reads write-first.
module mem_dual_port_resp #(
  parameter int              AW       = 3,
  parameter int              DW       = 4,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enA,
  input  logic          rwA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] DataInA,
  input  logic          enB,
  input  logic          rwB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataInB,
  output logic [DW-1:0] DataOutA,
  output logic [DW-1:0] DataOutB,
  output logic          validA,
  output logic          validB,
  output logic          busy,
  output logic          collision,
  output logic [7:0]    coll_count
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] doutA_q, doutB_q;
  logic          validA_q, validB_q;
  logic          collision_q;
  logic [7:0]    coll_count_q;

  logic          ready;
  logic          same_addr;
  logic          rdA, rdB, wrA, wrB;
  logic          coll;
  logic [DW-1:0] rd_dataA, rd_dataB;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == {AW{1'b1}}) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Request decode: everything is dropped while clearing; on a write/write clash port A wins.
  always_comb begin
    ready     = (state_q == READY);
    same_addr = (AddrA == AddrB);
    rdA       = ready & enA & rwA;
    rdB       = ready & enB & rwB;
    wrA       = ready & enA & ~rwA;
    wrB       = ready & enB & ~rwB & ~(wrA & same_addr);
    coll      = ready & enA & enB & same_addr & (~rwA | ~rwB);
  end

`ifdef MEM_BYPASS_EN
  always_comb begin
    rd_dataA = (wrB && same_addr) ? DataInB : mem_q[AddrA];
    rd_dataB = (wrA && same_addr) ? DataInA : mem_q[AddrB];
  end
`else
  always_comb begin
    rd_dataA = mem_q[AddrA];
    rd_dataB = mem_q[AddrB];
  end
`endif

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_ptr_q] <= INIT_VAL;
    end else begin
      if (wrA) mem_q[AddrA] <= DataInA;
      if (wrB) mem_q[AddrB] <= DataInB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      doutA_q      <= '0;
      doutB_q      <= '0;
      validA_q     <= 1'b0;
      validB_q     <= 1'b0;
      collision_q  <= 1'b0;
      coll_count_q <= 8'd0;
    end else begin
      validA_q    <= rdA;
      validB_q    <= rdB;
      collision_q <= coll;
      if (rdA)  doutA_q      <= rd_dataA;
      if (rdB)  doutB_q      <= rd_dataB;
      if (coll) coll_count_q <= sat_inc(coll_count_q);
    end
  end

  assign DataOutA   = doutA_q;
  assign DataOutB   = doutB_q;
  assign validA     = validA_q;
  assign validB     = validB_q;
  assign busy       = (state_q == CLEAR);
  assign collision  = collision_q;
  assign coll_count = coll_count_q;

endmodule
